// File: rtl/tdt_dm_hartctl.sv
// Debug-module hart control: DMCONTROL/DMSTATUS/HAWINDOW registers on APB plus per-hart halt, resume and reset handshakes.
// Define TDT_DM_HASEL_EN to build the hart-array mask (hasel, HAWINDOWSEL, single-window HAWINDOW).
module tdt_dm_hartctl #(
  parameter int CORE_NUM  = 4,
  parameter int HARTSEL_W = 10
) (
  input  logic                sys_apb_clk,
  input  logic                sys_apb_rst_b,
  input  logic                tdt_dmi_psel,
  input  logic                tdt_dmi_penable,
  input  logic                tdt_dmi_pwrite,
  input  logic [11:0]         tdt_dmi_paddr,
  input  logic [31:0]         tdt_dmi_pwdata,
  output logic [31:0]         tdt_dmi_prdata,
  output logic                tdt_dmi_pready,
  output logic                tdt_dmi_pslverr,
  input  logic [CORE_NUM-1:0] dtu_tdt_dm_halted,
  input  logic [CORE_NUM-1:0] dtu_tdt_dm_havereset,
  input  logic [CORE_NUM-1:0] pad_tdt_dm_core_unavail,
  output logic [CORE_NUM-1:0] tdt_dm_dtu_halt_req,
  output logic [CORE_NUM-1:0] tdt_dm_dtu_resume_req,
  output logic [CORE_NUM-1:0] tdt_dm_dtu_ack_havereset,
  output logic [CORE_NUM-1:0] tdt_dm_dtu_halt_on_reset,
  output logic [CORE_NUM-1:0] tdt_dm_pad_hartreset_n,
  output logic                tdt_dm_pad_ndmreset_n
);

  typedef enum logic {IDLE, PEND} resume_state_e;

  localparam logic [11:0] ADDR_DMCONTROL   = 12'h040;
  localparam logic [11:0] ADDR_DMSTATUS    = 12'h044;
  localparam logic [11:0] ADDR_HAWINDOWSEL = 12'h050;
  localparam logic [11:0] ADDR_HAWINDOW    = 12'h054;

  logic                 dmactive_q;
  logic                 hartreset_q;
  logic                 ndmreset_q;
  logic [HARTSEL_W-1:0] hartsello_q;
  logic                 hasel_q;
  logic [CORE_NUM-1:0]  hawindow_q;
  logic [CORE_NUM-1:0]  halt_req_q;
  logic [CORE_NUM-1:0]  ack_havereset_q;
  logic [CORE_NUM-1:0]  halt_on_reset_q;
  logic [CORE_NUM-1:0]  resumeack_q;
  logic [CORE_NUM-1:0]  resumeack_d;
  resume_state_e        rs_q [CORE_NUM];
  resume_state_e        rs_d [CORE_NUM];

  logic                 wr_en;
  logic                 ctl_wr;
  logic                 ctl_act;
  logic                 clr_all;
  logic                 wr_hasel;
  logic [HARTSEL_W-1:0] wr_hartsello;
  logic [CORE_NUM-1:0]  wr_sel;
  logic [CORE_NUM-1:0]  cur_sel;
  logic [CORE_NUM-1:0]  resume_go;
  logic [CORE_NUM-1:0]  st_halted;
  logic [CORE_NUM-1:0]  st_running;
  logic                 nonexist;
  logic [31:0]          dmcontrol_rd;
  logic [31:0]          dmstatus_rd;
  logic                 unused_pwdata;

  assign wr_en        = tdt_dmi_psel & tdt_dmi_penable & tdt_dmi_pwrite;
  assign ctl_wr       = wr_en & (tdt_dmi_paddr == ADDR_DMCONTROL);
  assign ctl_act      = ctl_wr & dmactive_q & tdt_dmi_pwdata[0];
  // An inactive DM, or a write that drops dmactive, holds everything else in its cleared state.
  assign clr_all      = ~dmactive_q | (ctl_wr & ~tdt_dmi_pwdata[0]);
  assign wr_hartsello = HARTSEL_W'(tdt_dmi_pwdata[25:16]);

`ifdef TDT_DM_HASEL_EN
  assign wr_hasel      = tdt_dmi_pwdata[26];
  assign unused_pwdata = ^{tdt_dmi_pwdata[27], tdt_dmi_pwdata[15:4]};

  always_ff @(posedge sys_apb_clk or negedge sys_apb_rst_b) begin
    if (!sys_apb_rst_b) begin
      hasel_q    <= 1'b0;
      hawindow_q <= '0;
    end else if (clr_all) begin
      hasel_q    <= 1'b0;
      hawindow_q <= '0;
    end else begin
      if (ctl_act) hasel_q <= tdt_dmi_pwdata[26];
      if (wr_en && tdt_dmi_paddr == ADDR_HAWINDOW) hawindow_q <= tdt_dmi_pwdata[CORE_NUM-1:0];
    end
  end
`else
  assign wr_hasel      = 1'b0;
  assign hasel_q       = 1'b0;
  assign hawindow_q    = '0;
  assign unused_pwdata = ^{tdt_dmi_pwdata[27:26], tdt_dmi_pwdata[15:4]};
`endif

  // Writes select harts by the hartsel being written; status and reset lines use the stored one.
  always_comb begin
    wr_sel  = '0;
    cur_sel = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      wr_sel[i]  = (wr_hartsello == HARTSEL_W'(i)) | (wr_hasel & hawindow_q[i]);
      cur_sel[i] = (hartsello_q == HARTSEL_W'(i)) | (hasel_q & hawindow_q[i]);
    end
  end

  always_ff @(posedge sys_apb_clk or negedge sys_apb_rst_b) begin
    if (!sys_apb_rst_b) begin
      dmactive_q      <= 1'b0;
      hartreset_q     <= 1'b0;
      ndmreset_q      <= 1'b0;
      hartsello_q     <= '0;
      halt_req_q      <= '0;
      ack_havereset_q <= '0;
      halt_on_reset_q <= '0;
    end else begin
      if (ctl_wr) dmactive_q <= tdt_dmi_pwdata[0];
      if (clr_all) begin
        hartreset_q     <= 1'b0;
        ndmreset_q      <= 1'b0;
        hartsello_q     <= '0;
        halt_req_q      <= '0;
        ack_havereset_q <= '0;
        halt_on_reset_q <= '0;
      end else begin
        ack_havereset_q <= '0;
        if (ctl_act) begin
          hartsello_q <= wr_hartsello;
          hartreset_q <= tdt_dmi_pwdata[29];
          ndmreset_q  <= tdt_dmi_pwdata[1];
          for (int i = 0; i < CORE_NUM; i++) begin
            if (wr_sel[i]) begin
              halt_req_q[i]      <= tdt_dmi_pwdata[31];
              ack_havereset_q[i] <= tdt_dmi_pwdata[28];
              if (tdt_dmi_pwdata[2])      halt_on_reset_q[i] <= 1'b0;
              else if (tdt_dmi_pwdata[3]) halt_on_reset_q[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign resume_go = {CORE_NUM{ctl_act & tdt_dmi_pwdata[30] & ~tdt_dmi_pwdata[31]}}
                     & wr_sel & dtu_tdt_dm_halted;

  always_ff @(posedge sys_apb_clk or negedge sys_apb_rst_b) begin
    if (!sys_apb_rst_b) begin
      for (int i = 0; i < CORE_NUM; i++) rs_q[i] <= IDLE;
      resumeack_q <= '0;
    end else begin
      for (int i = 0; i < CORE_NUM; i++) rs_q[i] <= rs_d[i];
      resumeack_q <= resumeack_d;
    end
  end

  // A pending resume completes on the first cycle the hart reports running.
  always_comb begin
    resumeack_d = resumeack_q;
    for (int i = 0; i < CORE_NUM; i++) begin
      rs_d[i] = rs_q[i];
      if (clr_all) begin
        rs_d[i]        = IDLE;
        resumeack_d[i] = 1'b0;
      end else begin
        case (rs_q[i])
          IDLE: begin
            if (resume_go[i]) begin
              rs_d[i]        = PEND;
              resumeack_d[i] = 1'b0;
            end
          end
          PEND: begin
            if (!dtu_tdt_dm_halted[i]) begin
              rs_d[i]        = IDLE;
              resumeack_d[i] = 1'b1;
            end
          end
          default: rs_d[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    tdt_dm_dtu_resume_req = '0;
    for (int i = 0; i < CORE_NUM; i++) tdt_dm_dtu_resume_req[i] = (rs_q[i] == PEND);
  end

  assign tdt_dm_dtu_halt_req       = halt_req_q;
  assign tdt_dm_dtu_ack_havereset  = ack_havereset_q;
  assign tdt_dm_dtu_halt_on_reset  = halt_on_reset_q;
  assign tdt_dm_pad_hartreset_n    = ~({CORE_NUM{hartreset_q}} & cur_sel);
  assign tdt_dm_pad_ndmreset_n     = ~ndmreset_q;
  assign tdt_dmi_pready            = 1'b1;
  assign tdt_dmi_pslverr           = 1'b0;

  // Returns {all, any} of a flag over the selected harts; an empty selection yields 2'b00.
  function automatic logic [1:0] all_any(input logic [CORE_NUM-1:0] flags,
                                         input logic [CORE_NUM-1:0] sel);
    all_any = {(|sel) & ~(|(sel & ~flags)), |(sel & flags)};
  endfunction

  assign st_halted  = dtu_tdt_dm_halted & ~pad_tdt_dm_core_unavail;
  assign st_running = ~dtu_tdt_dm_halted & ~pad_tdt_dm_core_unavail;
  assign nonexist   = (32'(hartsello_q) >= 32'(CORE_NUM)) & ~hasel_q;

  assign dmcontrol_rd = {2'b00, hartreset_q, 2'b00, hasel_q, 10'(hartsello_q),
                         14'h0, ndmreset_q, dmactive_q};
  assign dmstatus_rd  = {12'h000,
                         all_any(dtu_tdt_dm_havereset, cur_sel),
                         all_any(resumeack_q, cur_sel),
                         nonexist, nonexist,
                         all_any(pad_tdt_dm_core_unavail, cur_sel),
                         all_any(st_running, cur_sel),
                         all_any(st_halted, cur_sel),
                         1'b1, 3'b000, 4'd2};

  always_comb begin
    tdt_dmi_prdata = '0;
    if (tdt_dmi_psel) begin
      case (tdt_dmi_paddr)
        ADDR_DMCONTROL:   tdt_dmi_prdata = dmcontrol_rd;
        ADDR_DMSTATUS:    tdt_dmi_prdata = dmstatus_rd;
        ADDR_HAWINDOWSEL: tdt_dmi_prdata = '0;
        ADDR_HAWINDOW:    tdt_dmi_prdata = 32'(hawindow_q);
        default:          tdt_dmi_prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tdt_dm_hartctl.sv
// Randomised scoreboard bench for tdt_dm_hartctl against a register-level model of the debug-module rules.
module tb_tdt_dm_hartctl;

  localparam int CN = 4;
`ifdef TDT_DM_HASEL_EN
  localparam bit HASEL = 1'b1;
`else
  localparam bit HASEL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0]   paddr = '0;
  logic [31:0]   pwdata = '0;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [CN-1:0] halted = '0, havereset = '0, unavail = '0;
  logic [CN-1:0] halt_req, resume_req, ack_hr, hor, hartreset_n;
  logic          ndmreset_n;

  logic          nx_rst_n = 1'b0;
  logic [CN-1:0] nx_halted = '0, nx_havereset = '0, nx_unavail = '0;

  typedef struct {
    logic [CN-1:0] halt_req;
    logic [CN-1:0] resume_req;
    logic [CN-1:0] ack_hr;
    logic [CN-1:0] hor;
    logic [CN-1:0] hartreset_n;
    logic          ndmreset_n;
    logic          rd_valid;
    logic [31:0]   rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          m_dmactive, m_hasel, m_hartreset, m_ndmreset;
  int          m_hartsel;
  bit [CN-1:0] m_halt_req, m_pend, m_resumeack, m_ack_hr, m_hor, m_hawindow;

  tdt_dm_hartctl #(.CORE_NUM(CN), .HARTSEL_W(10)) dut (
    .sys_apb_clk              (clk),
    .sys_apb_rst_b            (rst_n),
    .tdt_dmi_psel             (psel),
    .tdt_dmi_penable          (penable),
    .tdt_dmi_pwrite           (pwrite),
    .tdt_dmi_paddr            (paddr),
    .tdt_dmi_pwdata           (pwdata),
    .tdt_dmi_prdata           (prdata),
    .tdt_dmi_pready           (pready),
    .tdt_dmi_pslverr          (pslverr),
    .dtu_tdt_dm_halted        (halted),
    .dtu_tdt_dm_havereset     (havereset),
    .pad_tdt_dm_core_unavail  (unavail),
    .tdt_dm_dtu_halt_req      (halt_req),
    .tdt_dm_dtu_resume_req    (resume_req),
    .tdt_dm_dtu_ack_havereset (ack_hr),
    .tdt_dm_dtu_halt_on_reset (hor),
    .tdt_dm_pad_hartreset_n   (hartreset_n),
    .tdt_dm_pad_ndmreset_n    (ndmreset_n)
  );

  always #5 clk = ~clk;

  function automatic bit m_selected(int i, int hs, bit ha);
    return (hs == i) || (ha && m_hawindow[i]);
  endfunction

  task automatic model_clear();
    m_hasel = 0; m_hartreset = 0; m_ndmreset = 0; m_hartsel = 0;
    m_halt_req = '0; m_pend = '0; m_resumeack = '0; m_ack_hr = '0; m_hor = '0; m_hawindow = '0;
  endtask

  task automatic model_reset();
    m_dmactive = 0;
    model_clear();
  endtask

  // Advances the model by one clock using the inputs that were held during that cycle.
  task automatic model_update();
    bit [CN-1:0] pend_old;
    bit          was_active;
    int          hs;
    bit          ha;
    pend_old   = m_pend;
    was_active = m_dmactive;
    m_ack_hr   = '0;
    for (int i = 0; i < CN; i++)
      if (pend_old[i] && !halted[i]) begin
        m_pend[i] = 0;
        m_resumeack[i] = 1;
      end
    if (psel && penable && pwrite) begin
      if (paddr == 12'h040) begin
        if (was_active && pwdata[0]) begin
          hs = int'(pwdata[25:16]);
          ha = HASEL && pwdata[26];
          for (int i = 0; i < CN; i++)
            if (m_selected(i, hs, ha)) begin
              m_halt_req[i] = pwdata[31];
              m_ack_hr[i]   = pwdata[28];
              if (pwdata[2])      m_hor[i] = 0;
              else if (pwdata[3]) m_hor[i] = 1;
              if (pwdata[30] && !pwdata[31] && !pend_old[i] && halted[i]) begin
                m_pend[i] = 1;
                m_resumeack[i] = 0;
              end
            end
          m_hartsel = hs; m_hasel = ha;
          m_hartreset = pwdata[29]; m_ndmreset = pwdata[1];
        end
        m_dmactive = pwdata[0];
      end else if (paddr == 12'h054 && was_active && HASEL) begin
        m_hawindow = pwdata[CN-1:0];
      end
    end
    if (!was_active || !m_dmactive) model_clear();
  endtask

  function automatic logic [31:0] model_read(logic [11:0] addr);
    logic [31:0] r;
    int n_sel, c_hr, c_ra, c_un, c_run, c_h;
    r = '0;
    n_sel = 0; c_hr = 0; c_ra = 0; c_un = 0; c_run = 0; c_h = 0;
    case (addr)
      12'h040: begin
        r[29] = m_hartreset; r[26] = m_hasel; r[25:16] = 10'(m_hartsel);
        r[1] = m_ndmreset; r[0] = m_dmactive;
      end
      12'h044: begin
        for (int i = 0; i < CN; i++)
          if (m_selected(i, m_hartsel, m_hasel)) begin
            n_sel++;
            c_hr  += int'(havereset[i]);
            c_ra  += int'(m_resumeack[i]);
            c_un  += int'(unavail[i]);
            c_run += int'(!halted[i] && !unavail[i]);
            c_h   += int'(halted[i] && !unavail[i]);
          end
        r[19] = (n_sel > 0) && (c_hr == n_sel);  r[18] = c_hr > 0;
        r[17] = (n_sel > 0) && (c_ra == n_sel);  r[16] = c_ra > 0;
        r[15] = (m_hartsel >= CN) && !m_hasel;   r[14] = r[15];
        r[13] = (n_sel > 0) && (c_un == n_sel);  r[12] = c_un > 0;
        r[11] = (n_sel > 0) && (c_run == n_sel); r[10] = c_run > 0;
        r[9]  = (n_sel > 0) && (c_h == n_sel);   r[8]  = c_h > 0;
        r[7] = 1'b1; r[3:0] = 4'd2;
      end
      12'h054: r = HASEL ? 32'(m_hawindow) : 32'h0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock of stimulus: update model, drive new inputs, queue what the DUT must show this cycle.
  task automatic applyStimulus(input logic s, input logic en, input logic wr,
                               input logic [11:0] addr, input logic [31:0] data);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) model_update();
    #1;
    rst_n = nx_rst_n; halted = nx_halted; havereset = nx_havereset; unavail = nx_unavail;
    psel = s; penable = en; pwrite = wr; paddr = addr; pwdata = data;
    if (!rst_n) model_reset();
    #1;
    e.halt_req   = m_halt_req;
    e.resume_req = m_pend;
    e.ack_hr     = m_ack_hr;
    e.hor        = m_hor;
    for (int i = 0; i < CN; i++) e.hartreset_n[i] = !(m_hartreset && m_selected(i, m_hartsel, m_hasel));
    e.ndmreset_n = !m_ndmreset;
    e.rd_valid   = psel;
    e.rdata      = model_read(paddr);
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("halt_req",      32'(halt_req),    32'(e.halt_req));
    cmp("resume_req",    32'(resume_req),  32'(e.resume_req));
    cmp("ack_havereset", 32'(ack_hr),      32'(e.ack_hr));
    cmp("halt_on_reset", 32'(hor),         32'(e.hor));
    cmp("hartreset_n",   32'(hartreset_n), 32'(e.hartreset_n));
    cmp("ndmreset_n",    32'(ndmreset_n),  32'(e.ndmreset_n));
    cmp("pready",        32'(pready),      32'h1);
    cmp("pslverr",       32'(pslverr),     32'h0);
    if (e.rd_valid) cmp("prdata", prdata, e.rdata);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data);
    applyStimulus(1'b1, 1'b1, 1'b1, addr, data);
  endtask

  task automatic apb_read(input logic [11:0] addr);
    applyStimulus(1'b1, 1'b0, 1'b0, addr, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic [11:0] addrs [5];
    addrs[0] = 12'h040; addrs[1] = 12'h044; addrs[2] = 12'h050; addrs[3] = 12'h054; addrs[4] = 12'h048;
    model_reset();
    $display("[TB] start, hasel feature %0d", HASEL);

    nx_rst_n = 1'b0; idle(3);
    nx_rst_n = 1'b1; idle(2);
    apb_write(12'h040, 32'h0000_0001);
    apb_read(12'h040);

    // halt hart 2, then report it halted
    apb_write(12'h040, 32'h8002_0001);
    nx_halted = 4'b0100; idle(1);
    apb_read(12'h044);

    // resume hart 2, it starts running three cycles later
    apb_write(12'h040, 32'h4002_0001);
    idle(3);
    nx_halted = 4'b0000; idle(2);
    apb_read(12'h044);

    // window-based multi-hart halt
    apb_write(12'h054, 32'h0000_000F);
    apb_read(12'h054);
    apb_read(12'h050);
    apb_write(12'h040, 32'h8400_0001);
    apb_read(12'h040);

    // out-of-range hartsel selects nothing
    apb_write(12'h040, 32'h0007_0001);
    apb_read(12'h044);
    apb_read(12'h040);

    // ackhavereset pulse
    nx_havereset = 4'b0001;
    apb_write(12'h040, 32'h1000_0001);
    idle(2);
    apb_read(12'h044);

    // halt-on-reset set, simultaneous set/clear, another hart
    apb_write(12'h040, 32'h0000_0009);
    apb_write(12'h040, 32'h0000_000D);
    apb_write(12'h040, 32'h0003_0009);

    // hart and system reset requests
    apb_write(12'h040, 32'h2001_0003);
    idle(1);
    apb_write(12'h040, 32'h0000_0001);

    // dmactive drop while a resume is pending
    nx_halted = 4'b1000;
    apb_write(12'h040, 32'h4003_0001);
    idle(2);
    apb_write(12'h040, 32'h0000_0000);
    idle(2);
    apb_write(12'h040, 32'h8003_0001);
    apb_write(12'h040, 32'h0003_0001);
    apb_read(12'h044);

    // ignored resumes: with haltreq, to a running hart
    nx_halted = 4'b0010;
    apb_write(12'h040, 32'hC001_0001);
    nx_halted = 4'b0000;
    apb_write(12'h040, 32'h4001_0001);
    idle(1);

    // reset mid-PEND
    nx_halted = 4'b0010;
    apb_write(12'h040, 32'h4001_0001);
    idle(1);
    nx_rst_n = 1'b0; idle(2);
    nx_rst_n = 1'b1; idle(1);
    apb_write(12'h040, 32'h0000_0001);
    apb_write(12'h040, 32'h0001_0001);
    apb_read(12'h044);

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) nx_halted = CN'($urandom);
      if ($urandom_range(0, 5) == 0) nx_havereset = CN'($urandom);
      if ($urandom_range(0, 9) == 0) nx_unavail = ($urandom_range(0, 2) == 0) ? CN'($urandom) : '0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          d = $urandom;
          d[25:16] = 10'($urandom_range(0, 6));
          d[0] = ($urandom_range(0, 7) != 0);
          apb_write(12'h040, d);
        end
        5, 6, 7: apb_read(addrs[$urandom_range(0, 4)]);
        8: apb_write(12'h054, $urandom);
        default: begin
          if ($urandom_range(0, 19) == 0) begin
            nx_rst_n = 1'b0; idle(1); nx_rst_n = 1'b1;
          end
          idle($urandom_range(1, 3));
        end
      endcase
    end

    idle(2);
    @(negedge clk);
    #1;
    cmp("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdt_dm_hartctl.md
TDT_DM_HARTCTL -- requirements
Module: tdt_dm_hartctl

Interface
REQ-001 SHALL have parameter CORE_NUM, default 4, legal 1..32: number of harts served.
REQ-002 SHALL have parameter HARTSEL_W, default 10: width of stored hartsel field.
REQ-003 SHALL use a single clock and an asynchronous active-low reset, with ports exactly as listed below.
REQ-004 sys_apb_clk  in  1  sole clock.
REQ-005 sys_apb_rst_b  in  1  asynchronous active-low reset.
REQ-006 tdt_dmi_psel, tdt_dmi_penable, tdt_dmi_pwrite  in  1 each  APB control.
REQ-007 tdt_dmi_paddr  in  12; tdt_dmi_pwdata  in  32; tdt_dmi_prdata  out  32; tdt_dmi_pready, tdt_dmi_pslverr  out  1 each.
REQ-008 dtu_tdt_dm_halted, dtu_tdt_dm_havereset, pad_tdt_dm_core_unavail  in  CORE_NUM each  per-hart status.
REQ-009 tdt_dm_dtu_halt_req, tdt_dm_dtu_resume_req, tdt_dm_dtu_ack_havereset, tdt_dm_dtu_halt_on_reset, tdt_dm_pad_hartreset_n  out  CORE_NUM each  per-hart controls.
REQ-010 tdt_dm_pad_ndmreset_n  out  1  system reset request, active low.

Function
REQ-011 APB: pready SHALL be 1 constantly; pslverr SHALL be 0 constantly; a write commits on psel&penable&pwrite; prdata SHALL be valid combinationally while psel=1, and SHALL read 0 at unmapped addresses.
REQ-012 Map (byte address): 0x040 DMCONTROL, 0x044 DMSTATUS (read-only), 0x050 HAWINDOWSEL, 0x054 HAWINDOW.
REQ-013 DMCONTROL fields: [31] haltreq, [30] resumereq, [29] hartreset, [28] ackhavereset, [26] hasel, [25:16] hartsello, [3] setresethaltreq, [2] clrresethaltreq, [1] ndmreset, [0] dmactive; reads return hasel, hartsello, hartreset, ndmreset, dmactive; all other bits read 0.
REQ-014 Selected set = hart hartsello when hartsello<CORE_NUM, OR'd with HAWINDOW mask when hasel=1; hartsello>=CORE_NUM selects no hart by index.
REQ-015 haltreq: per-hart halt_req register, updated on every DMCONTROL write for selected harts only to the written haltreq value; unselected harts keep their value; output driven directly from the register.
REQ-016 Resume FSM per hart, states IDLE and PEND: IDLE->PEND on a DMCONTROL write with resumereq=1, haltreq=0, hart selected and halted=1; entry clears resumeack[i] and sets resume_req[i]=1.
REQ-017 PEND->IDLE in the first cycle halted[i]=0: resume_req[i]=0 next cycle, resumeack[i]=1 sticky.
REQ-018 resumereq=1 with haltreq=1 SHALL be ignored; resumereq to a running hart SHALL be ignored; a new resumereq while PEND SHALL be ignored.
REQ-019 ackhavereset=1 SHALL pulse ack_havereset[i] for exactly one cycle for each selected hart.
REQ-020 setresethaltreq/clrresethaltreq set/clear halt_on_reset[i] for selected harts; both set simultaneously: clear wins.
REQ-021 hart reset outputs: hartreset_n[i]=~hartreset for selected harts and 1 for others; ndmreset_n=~ndmreset.
REQ-022 DMSTATUS: [19:18] all/anyhavereset, [17:16] all/anyresumeack, [15:14] all/anynonexistent, [13:12] all/anyunavail, [11:10] all/anyrunning, [9:8] all/anyhalted, [7]=1, [3:0]=2; "any"/"all" SHALL be evaluated over the selected set only (no selected hart: any=0, all=0); nonexistent flags SHALL be set when hartsello>=CORE_NUM and hasel=0.
REQ-023 running = ~halted & ~unavail; unavail SHALL take precedence over halted.
REQ-024 dmactive=0 SHALL synchronously clear all state except dmactive itself, including FSMs to IDLE; while dmactive=0, writes SHALL affect only dmactive.

Reset
REQ-025 On sys_apb_rst_b=0 all registers SHALL clear: halt_req, resume_req, ack_havereset, halt_on_reset = 0; hartreset_n, ndmreset_n = all 1; FSMs IDLE; resumeack=0; HAWINDOW=0.
REQ-026 Reset asserted mid-PEND SHALL drop resume_req without setting resumeack.

Configuration
REQ-027 Macro TDT_DM_HASEL_EN: when defined, hasel, HAWINDOWSEL and HAWINDOW (window 0 only, bits above CORE_NUM-1 read 0) are implemented.
REQ-028 When TDT_DM_HASEL_EN is undefined, hasel reads 0 and is ignored, and 0x050/0x054 read 0 and ignore writes.

Verification
REQ-029 CORE_NUM=4; write DMCONTROL=0x8002_0001 -> halt_req=4'b0100; set halted[2]=1 -> DMSTATUS[9:8]=2'b11.
REQ-030 hart2 halted, write 0x4002_0001 -> resume_req[2]=1 next cycle; drop halted[2] 3 cycles later -> resume_req[2]=0, DMSTATUS[17:16]=2'b11.
REQ-031 With macro: HAWINDOW=0xF, write 0x8400_0001 -> halt_req=4'hF; without macro -> halt_req=4'b0001.
REQ-032 Write hartsello=7 -> DMSTATUS[15:14]=2'b11, all halt_req unchanged.
REQ-033 havereset=4'b0001, write 0x1000_0001 -> ack_havereset=4'b0001 for exactly one cycle.
REQ-034 hart in PEND, write DMCONTROL=0 -> resume_req=0, state IDLE, resumeack stays 0.
